// File: rtl/n64_pkg.sv
// Shared constants, state encoding and helpers for the N64 joybus poll scheduler.
package n64_pkg;

    localparam logic [7:0]  CMD_STATUS        = 8'h00;
    localparam logic [7:0]  CMD_POLL          = 8'h01;
    localparam logic [15:0] ID_STD_CONTROLLER = 16'h0500;
    localparam logic [5:0]  RX_BITS_STATUS    = 6'd24;
    localparam logic [5:0]  RX_BITS_POLL      = 6'd32;

    // Encoding is exported unchanged on state_dbg.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PROBE_REQ  = 3'd1,
        ST_PROBE_WAIT = 3'd2,
        ST_POLL_REQ   = 3'd3,
        ST_POLL_WAIT  = 3'd4,
        ST_GAP        = 3'd5,
        ST_BACKOFF    = 3'd6
    } state_t;

    // Saturating increment used for the failed-transaction counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/n64_period_timer.sv
// Loadable 32-bit down-counter that stops at zero; expired is high while the count is zero.
module n64_period_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        expired
);

    logic [31:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == 32'd0);

endmodule

// File: rtl/n64_poll_scheduler.sv
// Joybus transaction sequencer for one controller port: probe, poll at a fixed
// period, count failures, retry and fall back to probing, publish validated data.
module n64_poll_scheduler
    import n64_pkg::*;
#(
    parameter int TICKS_PER_MICRO = 25,
    parameter int POLL_PERIOD_US  = 1000,
    parameter int WATCHDOG_US     = 300,
    parameter int MAX_RETRY       = 3
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        enable,
    output logic        phy_start,
    output logic [7:0]  phy_cmd,
    output logic [5:0]  phy_rx_bits,
    input  logic        phy_busy,
    input  logic        phy_done,
    input  logic        phy_timeout,
    input  logic [31:0] phy_rx_data,
    output logic [15:0] buttons,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        data_valid,
    output logic        connected,
    output logic [7:0]  timeout_count,
    output logic [2:0]  state_dbg
);

    // Expiry is observed one edge after the count reaches zero and the REQ state
    // needs one more edge to launch, so the period load is trimmed by two to make
    // start-to-start exactly one period. The watchdog decision is taken on the
    // edge that sees zero, so it is trimmed by one.
    localparam logic [31:0] PERIOD_LOAD   = 32'(TICKS_PER_MICRO * POLL_PERIOD_US) - 32'd2;
    localparam logic [31:0] WATCHDOG_LOAD = 32'(TICKS_PER_MICRO * WATCHDOG_US) - 32'd1;
    localparam logic [7:0]  LAST_RETRY    = 8'(MAX_RETRY - 1);

    state_t      state;
    logic [7:0]  retry;
    logic        period_expired;
    logic        wdog_expired;
    logic        launch;
    logic        id_ok;
    logic        probe_ok;
    logic        probe_bad;
    logic        poll_ok;
    logic        poll_bad;
    logic        to_backoff;
    logic        period_load;

    // Transaction events; phy_done always wins over a coincident timeout or watchdog expiry.
    always_comb begin
        launch     = (state == ST_PROBE_REQ || state == ST_POLL_REQ) && enable && !phy_busy;
        id_ok      = (phy_rx_data[23:8] == ID_STD_CONTROLLER);
        probe_ok   = (state == ST_PROBE_WAIT) && phy_done && id_ok;
        probe_bad  = (state == ST_PROBE_WAIT) &&
                     (phy_done ? !id_ok : (phy_timeout || wdog_expired));
        poll_ok    = (state == ST_POLL_WAIT) && phy_done;
        poll_bad   = (state == ST_POLL_WAIT) && !phy_done && (phy_timeout || wdog_expired);
        to_backoff = enable && (probe_bad || (poll_bad && retry == LAST_RETRY));
        period_load = (launch && state == ST_POLL_REQ) || to_backoff;
    end

    n64_period_timer u_period (
        .clk        (PCLK),
        .rst        (PRESET),
        .load       (period_load),
        .load_value (PERIOD_LOAD),
        .expired    (period_expired)
    );

    n64_period_timer u_watchdog (
        .clk        (PCLK),
        .rst        (PRESET),
        .load       (launch),
        .load_value (WATCHDOG_LOAD),
        .expired    (wdog_expired)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= ST_IDLE;
            retry         <= 8'd0;
            phy_start     <= 1'b0;
            phy_cmd       <= 8'd0;
            phy_rx_bits   <= 6'd0;
            buttons       <= 16'd0;
            stick_x       <= 8'd0;
            stick_y       <= 8'd0;
            data_valid    <= 1'b0;
            connected     <= 1'b0;
            timeout_count <= 8'd0;
        end else begin
            phy_start  <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_PROBE_REQ;
                end
                ST_PROBE_REQ: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (launch) begin
                        phy_start   <= 1'b1;
                        phy_cmd     <= CMD_STATUS;
                        phy_rx_bits <= RX_BITS_STATUS;
                        state       <= ST_PROBE_WAIT;
                    end
                end
                ST_PROBE_WAIT: begin
                    if (probe_ok) begin
                        connected <= 1'b1;
                        retry     <= 8'd0;
                        state     <= enable ? ST_POLL_REQ : ST_IDLE;
                    end else if (probe_bad) begin
                        timeout_count <= sat_inc8(timeout_count);
                        state         <= enable ? ST_BACKOFF : ST_IDLE;
                    end
                end
                ST_POLL_REQ: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (launch) begin
                        phy_start   <= 1'b1;
                        phy_cmd     <= CMD_POLL;
                        phy_rx_bits <= RX_BITS_POLL;
                        state       <= ST_POLL_WAIT;
                    end
                end
                ST_POLL_WAIT: begin
                    if (poll_ok) begin
                        buttons    <= phy_rx_data[31:16];
                        stick_x    <= phy_rx_data[15:8];
                        stick_y    <= phy_rx_data[7:0];
                        data_valid <= 1'b1;
                        retry      <= 8'd0;
                        state      <= enable ? ST_GAP : ST_IDLE;
                    end else if (poll_bad) begin
                        timeout_count <= sat_inc8(timeout_count);
                        if (retry == LAST_RETRY) begin
                            connected <= 1'b0;
                            retry     <= 8'd0;
                            state     <= enable ? ST_BACKOFF : ST_IDLE;
                        end else begin
                            retry <= retry + 8'd1;
                            state <= enable ? ST_GAP : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (!enable) state <= ST_IDLE;
                    else if (period_expired) state <= ST_POLL_REQ;
                end
                ST_BACKOFF: begin
                    if (!enable) state <= ST_IDLE;
                    else if (period_expired) state <= ST_PROBE_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Self-checking bench for n64_poll_scheduler with a scripted PHY responder and scoreboards.
module tb_n64_poll_scheduler;
    import n64_pkg::*;

    localparam int TPM        = 5;
    localparam int PUS        = 100;
    localparam int WUS        = 30;
    localparam int MR         = 3;
    localparam int PERIOD     = TPM * PUS;
    localparam int WDOG       = TPM * WUS;
    localparam int RESP_DELAY = 3;

    localparam int R_DONE    = 0;
    localparam int R_TIMEOUT = 1;
    localparam int R_BOTH    = 2;
    localparam int R_NONE    = 3;

    logic        PCLK;
    logic        PRESET;
    logic        enable;
    logic        phy_start;
    logic [7:0]  phy_cmd;
    logic [5:0]  phy_rx_bits;
    logic        phy_busy;
    logic        phy_done;
    logic        phy_timeout;
    logic [31:0] phy_rx_data;
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        data_valid;
    logic        connected;
    logic [7:0]  timeout_count;
    logic [2:0]  state_dbg;

    n64_poll_scheduler #(
        .TICKS_PER_MICRO (TPM),
        .POLL_PERIOD_US  (PUS),
        .WATCHDOG_US     (WUS),
        .MAX_RETRY       (MR)
    ) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .enable        (enable),
        .phy_start     (phy_start),
        .phy_cmd       (phy_cmd),
        .phy_rx_bits   (phy_rx_bits),
        .phy_busy      (phy_busy),
        .phy_done      (phy_done),
        .phy_timeout   (phy_timeout),
        .phy_rx_data   (phy_rx_data),
        .buttons       (buttons),
        .stick_x       (stick_x),
        .stick_y       (stick_y),
        .data_valid    (data_valid),
        .connected     (connected),
        .timeout_count (timeout_count),
        .state_dbg     (state_dbg)
    );

    typedef struct {
        int          kind;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [7:0] cmd;
        logic [5:0] bits;
    } start_t;

    resp_t       resp_q[$];
    start_t      exp_start_q[$];
    logic [31:0] exp_data_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   start_count = 0;
    int   last_start_cyc = 0;
    int   prev_start_cyc = 0;
    logic dv_prev = 1'b0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Monitor: scoreboard for phy_start commands and published data.
    always @(negedge PCLK) begin
        start_t      e;
        logic [31:0] d;
        if (phy_start === 1'b1) begin
            vectors++;
            if (exp_start_q.size() == 0) begin
                miscompares++;
                $display("FAIL start_unexpected: got cmd=%h bits=%0d, required no start", phy_cmd, phy_rx_bits);
            end else begin
                e = exp_start_q.pop_front();
                if (phy_cmd !== e.cmd || phy_rx_bits !== e.bits) begin
                    miscompares++;
                    $display("FAIL start_cmd: got cmd=%h bits=%0d, required cmd=%h bits=%0d", phy_cmd, phy_rx_bits, e.cmd, e.bits);
                end
            end
            $display("start #%0d at cycle %0d cmd=%h bits=%0d", start_count + 1, cyc, phy_cmd, phy_rx_bits);
            prev_start_cyc = last_start_cyc;
            last_start_cyc = cyc;
            start_count++;
        end
        if (data_valid === 1'b1) begin
            vectors++;
            if (exp_data_q.size() == 0) begin
                miscompares++;
                $display("FAIL data_unexpected: got %h, required no data_valid", {buttons, stick_x, stick_y});
            end else begin
                d = exp_data_q.pop_front();
                if ({buttons, stick_x, stick_y} !== d) begin
                    miscompares++;
                    $display("FAIL data_value: got %h, required %h", {buttons, stick_x, stick_y}, d);
                end
            end
            vectors++;
            if (dv_prev !== 1'b0) begin
                miscompares++;
                $display("FAIL data_valid_width: got pulse longer than 1 cycle, required 1");
            end
            $display("data_valid at cycle %0d buttons=%h x=%h y=%h", cyc, buttons, stick_x, stick_y);
        end
        dv_prev = data_valid;
    end

    // Scripted PHY: one queued response per phy_start; R_NONE stays silent.
    initial begin
        resp_t r;
        phy_busy    = 1'b0;
        phy_done    = 1'b0;
        phy_timeout = 1'b0;
        phy_rx_data = 32'd0;
        forever begin
            @(negedge PCLK);
            if (phy_start === 1'b1 && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.kind != R_NONE) begin
                    phy_busy = 1'b1;
                    repeat (RESP_DELAY - 1) @(negedge PCLK);
                    phy_busy    = 1'b0;
                    phy_rx_data = r.data;
                    phy_done    = (r.kind == R_DONE || r.kind == R_BOTH);
                    phy_timeout = (r.kind == R_TIMEOUT || r.kind == R_BOTH);
                    @(negedge PCLK);
                    phy_done    = 1'b0;
                    phy_timeout = 1'b0;
                end
            end
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL global_timeout: simulation exceeded its cycle budget");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        int target;
        target = start_count + n;
        for (int i = 0; i < budget && start_count < target; i++) tick();
        ok = (start_count >= target);
    endtask

    task automatic wait_data_drained(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_data_q.size() != 0; i++) tick();
        ok = (exp_data_q.size() == 0);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({phy_start, phy_cmd, phy_rx_bits, data_valid, connected, timeout_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got start=%b cmd=%h bits=%0d dv=%b conn=%b tc=%0d, required all 0",
                     phy_start, phy_cmd, phy_rx_bits, data_valid, connected, timeout_count);
        end
        vectors++;
        if ({buttons, stick_x, stick_y} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, required 0", {buttons, stick_x, stick_y});
        end
        PRESET = 1'b0;
        repeat (10) tick();
        vectors++;
        if (start_count != 0 || state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL idle_disabled: got starts=%0d state=%0d, required 0 starts state=%0d", start_count, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_probe_first_poll();
        bit ok;
        resp_q.push_back('{R_DONE, 32'h0005_0001});
        exp_start_q.push_back('{CMD_STATUS, RX_BITS_STATUS});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        resp_q.push_back('{R_DONE, 32'h8000_7F81});
        exp_data_q.push_back(32'h8000_7F81);
        enable = 1'b1;
        wait_starts(2, 100, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL probe_starts: got %0d starts, required 2 within budget", start_count);
        end
        vectors++;
        if (last_start_cyc - prev_start_cyc != RESP_DELAY + 1) begin
            miscompares++;
            $display("FAIL probe_to_poll: got %0d cycles, required %0d", last_start_cyc - prev_start_cyc, RESP_DELAY + 1);
        end
        vectors++;
        if (connected !== 1'b1) begin
            miscompares++;
            $display("FAIL connected_after_probe: got %b, required 1", connected);
        end
        wait_data_drained(50, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL first_poll_data: got no data_valid, required one");
        end
        tick();
        vectors++;
        if (data_valid !== 1'b0 || buttons !== 16'h8000 || stick_x !== 8'h7F || stick_y !== 8'h81) begin
            miscompares++;
            $display("FAIL data_hold: got dv=%b %h/%h/%h, required 0 8000/7f/81", data_valid, buttons, stick_x, stick_y);
        end
    endtask

    task automatic test_period();
        bit ok;
        resp_q.push_back('{R_DONE, 32'h1234_FF00});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        exp_data_q.push_back(32'h1234_FF00);
        wait_starts(1, PERIOD + 20, ok);
        vectors++;
        if (!ok || last_start_cyc - prev_start_cyc != PERIOD) begin
            miscompares++;
            $display("FAIL poll_period: got ok=%b interval=%0d, required %0d", ok, last_start_cyc - prev_start_cyc, PERIOD);
        end
        wait_data_drained(50, ok);
        vectors++;
        if (!ok || state_dbg !== ST_GAP) begin
            miscompares++;
            $display("FAIL period_gap: got drained=%b state=%0d, required 1 state=%0d", ok, state_dbg, ST_GAP);
        end
    endtask

    task automatic test_retry_exhaust();
        bit         ok;
        int         fall_cyc;
        logic [7:0] tc0;
        tc0 = timeout_count;
        fall_cyc = 0;
        for (int k = 0; k < MR; k++) begin
            resp_q.push_back('{R_TIMEOUT, 32'd0});
            exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        end
        exp_start_q.push_back('{CMD_STATUS, RX_BITS_STATUS});
        resp_q.push_back('{R_DONE, 32'h0005_0002});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        resp_q.push_back('{R_NONE, 32'd0});
        for (int k = 1; k <= MR; k++) begin
            ok = 1'b0;
            for (int i = 0; i < PERIOD + 50 && !ok; i++) begin
                tick();
                ok = (timeout_count == 8'(tc0 + k));
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL retry_count_%0d: got tc=%0d, required %0d", k, timeout_count, tc0 + k);
            end
            vectors++;
            if (k < MR && connected !== 1'b1) begin
                miscompares++;
                $display("FAIL retry_connected_%0d: got %b, required 1", k, connected);
            end else if (k == MR && (connected !== 1'b0 || state_dbg !== ST_BACKOFF)) begin
                miscompares++;
                $display("FAIL retry_exhausted: got conn=%b state=%0d, required 0 state=%0d", connected, state_dbg, ST_BACKOFF);
            end
            if (k == MR) fall_cyc = cyc;
        end
        wait_starts(1, PERIOD + 20, ok);
        vectors++;
        if (!ok || last_start_cyc - fall_cyc != PERIOD) begin
            miscompares++;
            $display("FAIL backoff_len: got ok=%b %0d cycles, required %0d", ok, last_start_cyc - fall_cyc, PERIOD);
        end
    endtask

    task automatic test_watchdog();
        bit         ok;
        int         s;
        logic [7:0] tc0;
        tc0 = timeout_count;
        wait_starts(1, 50, ok);
        s = last_start_cyc;
        vectors++;
        if (!ok || connected !== 1'b1) begin
            miscompares++;
            $display("FAIL reprobe: got ok=%b conn=%b, required poll start and conn=1", ok, connected);
        end
        ok = 1'b0;
        for (int i = 0; i < WDOG + 20 && !ok; i++) begin
            tick();
            ok = (timeout_count == 8'(tc0 + 1));
        end
        vectors++;
        if (!ok || cyc - s != WDOG) begin
            miscompares++;
            $display("FAIL watchdog_delay: got ok=%b %0d cycles, required %0d", ok, cyc - s, WDOG);
        end
        vectors++;
        if (state_dbg !== ST_GAP || connected !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog_retry: got state=%0d conn=%b, required state=%0d conn=1", state_dbg, connected, ST_GAP);
        end
    endtask

    task automatic test_done_and_timeout();
        bit         ok;
        logic [7:0] tc0;
        tc0 = timeout_count;
        resp_q.push_back('{R_BOTH, 32'h0001_0000});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        exp_data_q.push_back(32'h0001_0000);
        wait_starts(1, PERIOD + 20, ok);
        wait_data_drained(50, ok);
        vectors++;
        if (!ok || buttons !== 16'h0001) begin
            miscompares++;
            $display("FAIL both_data: got ok=%b buttons=%h, required 0001", ok, buttons);
        end
        vectors++;
        if (timeout_count !== tc0) begin
            miscompares++;
            $display("FAIL both_tc: got %0d, required %0d", timeout_count, tc0);
        end
    endtask

    task automatic test_reset_mid_poll();
        bit ok;
        resp_q.push_back('{R_NONE, 32'd0});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        wait_starts(1, PERIOD + 20, ok);
        repeat (5) tick();
        vectors++;
        if (!ok || state_dbg !== ST_POLL_WAIT) begin
            miscompares++;
            $display("FAIL pre_reset_state: got ok=%b state=%0d, required %0d", ok, state_dbg, ST_POLL_WAIT);
        end
        PRESET = 1'b1;
        #1;
        vectors++;
        if ({phy_start, phy_cmd, phy_rx_bits, data_valid, connected, timeout_count, buttons, stick_x, stick_y, state_dbg} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got conn=%b tc=%0d buttons=%h cmd=%h state=%0d, required all 0",
                     connected, timeout_count, buttons, phy_cmd, state_dbg);
        end
        repeat (3) tick();
    endtask

    task automatic test_enable_gap();
        bit ok;
        int n;
        resp_q.push_back('{R_DONE, 32'h0005_0001});
        exp_start_q.push_back('{CMD_STATUS, RX_BITS_STATUS});
        exp_start_q.push_back('{CMD_POLL, RX_BITS_POLL});
        resp_q.push_back('{R_DONE, 32'hA5A5_0102});
        exp_data_q.push_back(32'hA5A5_0102);
        PRESET = 1'b0;
        wait_starts(2, 100, ok);
        wait_data_drained(50, ok);
        vectors++;
        if (!ok || state_dbg !== ST_GAP) begin
            miscompares++;
            $display("FAIL restart: got ok=%b state=%0d, required state=%0d", ok, state_dbg, ST_GAP);
        end
        enable = 1'b0;
        tick();
        vectors++;
        if (state_dbg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL gap_disable: got state=%0d, required %0d", state_dbg, ST_IDLE);
        end
        n = start_count;
        repeat (3 * PERIOD) tick();
        vectors++;
        if (start_count != n || state_dbg !== ST_IDLE || connected !== 1'b1 || buttons !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL parked: got starts=+%0d state=%0d conn=%b buttons=%h, required +0 idle 1 a5a5",
                     start_count - n, state_dbg, connected, buttons);
        end
    endtask

    initial begin
        PRESET = 1'b1;
        enable = 1'b0;
        test_reset();
        test_probe_first_poll();
        test_period();
        test_retry_exhaust();
        test_watchdog();
        test_done_and_timeout();
        test_reset_mid_poll();
        test_enable_gap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
Sequences transactions on the N64 joybus transceiver (PHY) for one controller port. After reset it probes with the status command (0x00), verifies the standard-controller ID, then issues poll commands (0x01) at a fixed period. It handles timeouts, retries and re-probing, and publishes a latched, validated snapshot of buttons and stick to the rest of the design.

Parameters:
TICKS_PER_MICRO, 25, PCLK cycles per microsecond
POLL_PERIOD_US, 1000, poll start-to-start interval in microseconds
WATCHDOG_US, 300, maximum wait for phy_done/phy_timeout after phy_start before forcing a timeout
MAX_RETRY, 3, consecutive poll failures tolerated before dropping back to probe

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous, active-high reset
enable  in  1  level; 0 parks the scheduler in IDLE once any in-flight transaction ends
phy_start  out  1  one-cycle pulse launching a PHY transaction
phy_cmd  out  8  command byte; held stable from phy_start until phy_done/phy_timeout
phy_rx_bits  out  6  expected response length: 24 for status, 32 for poll
phy_busy  in  1  PHY transaction in progress
phy_done  in  1  one-cycle pulse; phy_rx_data is valid
phy_timeout  in  1  one-cycle pulse; PHY saw no or short response
phy_rx_data  in  32  response, right-aligned, first received bit at MSB of valid field
buttons  out  16  latched button word, phy_rx_data[31:16] of the last good poll
stick_x  out  8  phy_rx_data[15:8], two's complement
stick_y  out  8  phy_rx_data[7:0], two's complement
data_valid  out  1  one-cycle pulse when buttons/stick update
connected  out  1  high after a successful probe; low after retry exhaustion
timeout_count  out  8  saturating count of failed transactions (PHY or watchdog)
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async): state=IDLE; all outputs 0; retry count, timers and the watchdog cleared. Reset mid-transaction abandons it; PHY-side cleanup belongs to the PHY.
- States: IDLE, PROBE_REQ, PROBE_WAIT, POLL_REQ, POLL_WAIT, GAP, BACKOFF.
- IDLE: enable=1 -> PROBE_REQ.
- PROBE_REQ / POLL_REQ: wait until phy_busy=0, then pulse phy_start for exactly one cycle with phy_cmd/phy_rx_bits set (0x00/24 or 0x01/32). On the same edge, load the watchdog and, for polls, the period timer. Go to *_WAIT.
- PROBE_WAIT:
  - phy_done with phy_rx_data[23:8]==16'h0500 -> connected<=1, retry<=0, POLL_REQ.
  - phy_done with a wrong ID, phy_timeout, or watchdog expiry -> timeout_count++ (saturate at 255), BACKOFF.
- POLL_WAIT:
  - phy_done -> latch buttons/stick, pulse data_valid the next cycle, retry<=0, GAP.
  - phy_timeout or watchdog expiry -> timeout_count++, retry++. If retry reaches MAX_RETRY: connected<=0, retry<=0, BACKOFF. Otherwise go to GAP.
- GAP: wait for the period timer to expire (POLL_PERIOD_US*TICKS_PER_MICRO cycles after the poll phy_start), then POLL_REQ. Go to IDLE instead if enable=0.
- BACKOFF: wait one full POLL_PERIOD, then PROBE_REQ (or IDLE if enable=0).
- phy_done and phy_timeout in the same cycle: done wins; the timeout is ignored.
- phy_done/phy_timeout outside a *_WAIT state: ignored.
- enable falling during *_WAIT: complete the wait normally, then IDLE. connected and the latched data hold their values.
- Timers: 32-bit down-counters; expiry is count==0. If the period timer expires before the transaction completes, POLL_REQ is entered right after the *_WAIT exit (no skipped-period accounting).
- Outputs are registered. Latency is phy_done to data_valid = 1 cycle, and phy_done to the next REQ state = 1 cycle at minimum.

Decomposition:
- Package n64_pkg holds:
  - CMD_STATUS=8'h00, CMD_POLL=8'h01, ID_STD_CONTROLLER=16'h0500
  - RX_BITS_STATUS=24, RX_BITS_POLL=32
  - the state enum (3-bit encoding used by state_dbg)
- One sub-module, n64_period_timer: load/count-to-zero down-counter with an expired flag. Instantiate it twice, once for the period timer and once for the watchdog.

Test Plan:
- Reset, enable=1, PHY model answers status with 24'h050001 -> one phy_start with cmd 0x00/24 bits, then connected=1 and a poll start with cmd 0x01/32 bits on the following cycles.
- Poll returns 32'h8000_7F81 -> buttons=16'h8000, stick_x=8'h7F, stick_y=8'h81, data_valid for exactly 1 cycle. The next phy_start comes exactly 25000 cycles after the previous one.
- Three consecutive poll phy_timeout -> timeout_count=3, connected=0 after the third. Then BACKOFF of 25000 cycles, then a cmd 0x00 start.
- PHY never responds -> watchdog fires 7500 cycles after phy_start, timeout_count increments, retry path taken.
- phy_done and phy_timeout in the same cycle with data 32'h0001_0000 -> data latched (buttons=16'h0001), timeout_count unchanged.
- Assert PRESET mid POLL_WAIT; deassert enable during GAP -> all outputs 0 immediately on reset. With enable=0, no further phy_start and state_dbg=IDLE.
